nibble_pair_packer: RTL



---
 rtl/nibble_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 87 ++++++++
 rtl/nibble_pair_packer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// -----------------------------------------------------------------------------
// nibble_pkg
// Shared types and constants for the nibble pair packer.
//   NIBBLE_W / BYTE_W : data widths of the input and output streams
//   PAD_NIBBLE        : value used to fill the low half of a flushed byte
//   state_e           : packer FSM states (S_HI = waiting for high nibble,
//                       S_LO = high nibble held, waiting for low nibble)
//   fifo_entry_t      : one output FIFO entry {pad flag, byte}
// -----------------------------------------------------------------------------
package nibble_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  localparam logic [NIBBLE_W-1:0] PAD_NIBBLE = 4'h0;

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } state_e;

  typedef struct packed {
    logic              pad;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Build a FIFO entry from a high/low nibble pair.
  function automatic fifo_entry_t make_entry(input logic [NIBBLE_W-1:0] hi,
                                             input logic [NIBBLE_W-1:0] lo,
                                             input logic                pad);
    fifo_entry_t e;
    e.pad  = pad;
    e.data = {hi, lo};
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-in first-out buffer with an occupancy counter.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : entry to write
//   pop        : discard the head entry (ignored when empty)
//   head_data  : current head entry (meaningful only when !empty)
//   full/empty : derived from the occupancy counter
// DEPTH must be a power of two, minimum 2, so pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Storage is a plain array so it can map onto distributed RAM; it is not
  // reset because its contents are only observed through the head while
  // the FIFO is non-empty.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q,    cnt_d;

  logic do_push;
  logic do_pop;

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop  & ~empty;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/nibble_pair_packer.sv
// -----------------------------------------------------------------------------
// nibble_pair_packer
// Assembles bytes from a valid/ready stream of nibbles and buffers them in a
// small FIFO toward a byte-wide valid/ready consumer.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake (in_ready = FIFO not full)
//   in_nibble             : data nibble
//   in_last               : last nibble of a packet; flushes a lone high nibble
//   mode                  : 0 = concat two nibbles, 1 = replicate one nibble
//   out_valid/out_ready   : output handshake on the FIFO head
//   out_byte, out_pad     : head byte and "low nibble is padding" flag
//   byte_count            : number of bytes popped, wraps silently
// -----------------------------------------------------------------------------
module nibble_pair_packer
  import nibble_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_nibble,
  input  logic                in_last,
  input  logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BYTE_W-1:0]   out_byte,
  output logic                out_pad,
  output logic [CNT_W-1:0]    byte_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q, state_d;
  logic [NIBBLE_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0]    byte_count_q, byte_count_d;

  logic        accept;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  fifo_entry_t push_entry;
  fifo_entry_t head_entry;

  // in_ready depends only on registered FIFO occupancy, so there is no
  // combinational path from out_ready back to the producer.
  assign in_ready  = ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Head is forced to zero when empty so the outputs read clean after reset.
  assign out_byte   = fifo_empty ? '0   : head_entry.data;
  assign out_pad    = fifo_empty ? 1'b0 : head_entry.pad;
  assign byte_count = byte_count_q;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      case (state_q)
        S_HI: begin
          if (mode) begin
            push       = 1'b1;
            push_entry = make_entry(in_nibble, in_nibble, 1'b0);
          end else if (in_last) begin
            push       = 1'b1;
            push_entry = make_entry(in_nibble, PAD_NIBBLE, 1'b1);
          end else begin
            hi_d    = in_nibble;
            state_d = S_LO;
          end
        end
        S_LO: begin
          // A held high nibble only exists in concat mode, so the current
          // mode input is irrelevant here.
          push       = 1'b1;
          push_entry = make_entry(hi_q, in_nibble, 1'b0);
          hi_d       = PAD_NIBBLE;
          state_d    = S_HI;
        end
        default: begin
          state_d = S_HI;
        end
      endcase
    end
  end

  always_comb begin
    byte_count_d = byte_count_q;
    if (pop) begin
      byte_count_d = byte_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HI;
      hi_q         <= PAD_NIBBLE;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      byte_count_q <= byte_count_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
